// File: rtl/player_pkg.sv
// Shared definitions for the player controller: FSM state codes, button
// indices and fixed datapath widths.
package player_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK_L  = 3'd1,
    WALK_R  = 3'd2,
    ATTACK  = 3'd3,
    RECOVER = 3'd4,
    BLOCK   = 3'd5
  } state_t;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_ATK   = 2;
  localparam int BTN_BLK   = 3;
  localparam int NUM_BTNS  = 4;

  localparam int POS_W  = 10;
  localparam int FCNT_W = 8;

  // ATTACK and RECOVER run to completion and ignore new attack presses.
  function automatic logic is_busy(input state_t s);
    return (s == ATTACK) || (s == RECOVER);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input: two-flop synchronizer followed by a debouncer that only
// follows the input after it has stayed different for DEBOUNCE_CYCLES clocks.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // Any clock where input matches the level restarts the qualification run.
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/player_ctrl.sv
// Player controller: debounced buttons drive a frame-paced movement/combat FSM
// and a clamped horizontal position.
module player_ctrl
  import player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 576,
  parameter int X_INIT          = 64,
  parameter int STEP            = 4,
  parameter int ATTACK_FRAMES   = 8,
  parameter int RECOVER_FRAMES  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       buttons,
  input  logic             frame_tick,
  output logic [POS_W-1:0] pos_x,
  output logic [2:0]       state,
  output logic             attack_start,
  output logic             blocking
);

  localparam logic [POS_W-1:0]  X_MIN_10  = POS_W'(X_MIN);
  localparam logic [POS_W-1:0]  X_MAX_10  = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]  X_INIT_10 = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]  STEP_10   = POS_W'(STEP);
  localparam logic [POS_W:0]    X_MIN_11  = (POS_W+1)'(X_MIN);
  localparam logic [POS_W:0]    X_MAX_11  = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0]    STEP_11   = (POS_W+1)'(STEP);
  localparam logic [FCNT_W-1:0] ATK_LAST  = FCNT_W'(ATTACK_FRAMES - 1);
  localparam logic [FCNT_W-1:0] REC_LAST  = FCNT_W'(RECOVER_FRAMES - 1);

  logic [NUM_BTNS-1:0] w_db;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (buttons[gi]),
      .o_level(w_db[gi])
    );
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [POS_W-1:0]  r_pos_x;
  logic [POS_W-1:0]  w_pos_next;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_atk_prev;
  logic              r_pending;
  logic              r_attack_start;

  logic w_atk_rise;
  logic w_atk_accept;
  logic w_atk_req;
  logic w_left_only;
  logic w_right_only;
  logic [POS_W-1:0] w_pos_dec;
  logic [POS_W-1:0] w_pos_inc;

  assign w_atk_rise   = w_db[BTN_ATK] & ~r_atk_prev;
  assign w_atk_accept = w_atk_rise & ~is_busy(r_state);
  // A press landing on the tick clock itself is honoured without waiting a frame.
  assign w_atk_req    = r_pending | w_atk_accept;
  assign w_left_only  = w_db[BTN_LEFT] & ~w_db[BTN_RIGHT];
  assign w_right_only = w_db[BTN_RIGHT] & ~w_db[BTN_LEFT];

  // Bounds compared one bit wider than pos_x so the step can never wrap.
  assign w_pos_dec = ({1'b0, r_pos_x} < (X_MIN_11 + STEP_11)) ? X_MIN_10 : (r_pos_x - STEP_10);
  assign w_pos_inc = (({1'b0, r_pos_x} + STEP_11) > X_MAX_11) ? X_MAX_10 : (r_pos_x + STEP_10);

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos_x;
    case (r_state)
      IDLE, WALK_L, WALK_R, BLOCK: begin
        if (frame_tick) begin
          if (w_atk_req)           w_state_next = ATTACK;
          else if (w_db[BTN_BLK])  w_state_next = BLOCK;
          else if (w_left_only)    w_state_next = WALK_L;
          else if (w_right_only)   w_state_next = WALK_R;
          else                     w_state_next = IDLE;
        end
      end
      ATTACK: begin
        if (frame_tick && (r_frame_cnt == ATK_LAST)) w_state_next = RECOVER;
      end
      RECOVER: begin
        if (frame_tick && (r_frame_cnt == REC_LAST)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (frame_tick) begin
      if (w_state_next == WALK_L)      w_pos_next = w_pos_dec;
      else if (w_state_next == WALK_R) w_pos_next = w_pos_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_pos_x        <= X_INIT_10;
      r_frame_cnt    <= '0;
      r_atk_prev     <= 1'b0;
      r_pending      <= 1'b0;
      r_attack_start <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pos_x        <= w_pos_next;
      r_atk_prev     <= w_db[BTN_ATK];
      r_attack_start <= frame_tick && (w_state_next == ATTACK) && (r_state != ATTACK);
      if (w_state_next != r_state) r_frame_cnt <= '0;
      else if (frame_tick)         r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      // Pending lives for at most one frame; busy-state presses never set it.
      if (frame_tick)        r_pending <= 1'b0;
      else if (w_atk_accept) r_pending <= 1'b1;
    end
  end

  assign pos_x        = r_pos_x;
  assign state        = r_state;
  assign attack_start = r_attack_start;
  assign blocking     = (r_state == BLOCK);

endmodule
